// File: rtl/pcie_up_txbuf_if.sv
// -----------------------------------------------------------------------------
// pcie_up_txbuf_if
// Bundles the two streaming sides of the upload transmit buffer.
//   UPK_TX_*  : beat stream from the upload arbiter (REQ/ACK space handshake,
//               DVLD-qualified beats with SOP/EOP framing and dword MASK,
//               END marks a finished channel transfer).
//   TX_ST_*   : Avalon-ST TX beats towards the PCIe hard IP, readyLatency 0.
// Modports:
//   slave  : the buffer itself (consumes UPK_TX_*, produces TX_ST_*).
//   master : the environment (arbiter + hard IP side).
// -----------------------------------------------------------------------------
interface pcie_up_txbuf_if;
   logic        UPK_TX_REQ;
   logic        UPK_TX_ACK;
   logic        UPK_TX_DVLD;
   logic [63:0] UPK_TX_DATA;
   logic [1:0]  UPK_TX_MASK;
   logic        UPK_TX_SOP;
   logic        UPK_TX_EOP;
   logic        UPK_TX_END;

   logic        TX_ST_VALID;
   logic        TX_ST_READY;
   logic [63:0] TX_ST_DATA;
   logic        TX_ST_SOP;
   logic        TX_ST_EOP;
   logic        TX_ST_EMPTY;

   modport slave (
      input  UPK_TX_REQ, UPK_TX_DVLD, UPK_TX_DATA, UPK_TX_MASK,
             UPK_TX_SOP, UPK_TX_EOP, UPK_TX_END, TX_ST_READY,
      output UPK_TX_ACK, TX_ST_VALID, TX_ST_DATA, TX_ST_SOP,
             TX_ST_EOP, TX_ST_EMPTY
   );

   modport master (
      output UPK_TX_REQ, UPK_TX_DVLD, UPK_TX_DATA, UPK_TX_MASK,
             UPK_TX_SOP, UPK_TX_EOP, UPK_TX_END, TX_ST_READY,
      input  UPK_TX_ACK, TX_ST_VALID, TX_ST_DATA, TX_ST_SOP,
             TX_ST_EOP, TX_ST_EMPTY
   );
endinterface

// File: rtl/pcie_up_txbuf.sv
// -----------------------------------------------------------------------------
// pcie_up_txbuf
// Store-and-forward packet FIFO between the upload arbiter and the PCIe hard IP
// TX streaming port. Beats are written whenever DVLD=1 (dropped only when the
// FIFO is full); whole packets are forwarded gap-free once their EOP is stored.
// UPK_TX_ACK is a registered space-available level: a worst-case packet plus
// the skid beats still fit.
//
// Ports:
//   PCIE_CLK    : sole clock
//   PCIE_RST_N  : asynchronous active-low reset
//   bus         : pcie_up_txbuf_if.slave (UPK_TX_* in, TX_ST_* out)
//   ERR_FLAG    : sticky errors [0] overflow, [1] framing, [2] oversize
//
// Optional feature macro: PCIE_UP_TXBUF_ERRCHK_EN
//   defined   : framing/oversize checker drives ERR_FLAG[2:1]
//   undefined : ERR_FLAG[2:1] tied to 0, checker absent
// -----------------------------------------------------------------------------
module pcie_up_txbuf #(
   parameter int P_DEPTH     = 256,
   parameter int P_MAX_BEATS = 34,
   parameter int P_SKID      = 4
) (
   input  logic             PCIE_CLK,
   input  logic             PCIE_RST_N,
   pcie_up_txbuf_if.slave   bus,
   output logic [2:0]       ERR_FLAG
);

   localparam int AW = $clog2(P_DEPTH);
   localparam int PW = AW + 1;
   localparam int WW = 68;

   typedef enum logic {O_IDLE, O_SEND} ostate_t;

   logic [WW-1:0] mem [P_DEPTH];
   logic [PW-1:0] wptr, rptr, occ, free_cnt;
   logic [PW-1:0] pkt_cnt, pkt_cnt_nxt;
   logic [WW-1:0] wr_word, head_word, out_word;
   logic          full, wr_en, wr_eop, pop, pop_eop, load;
   logic          ack_q, err_ovf;
   ostate_t       state, state_nxt;

   assign occ       = wptr - rptr;
   assign free_cnt  = PW'(P_DEPTH) - occ;
   assign full      = (occ == PW'(P_DEPTH));
   assign wr_en     = bus.UPK_TX_DVLD & ~full;
   assign wr_eop    = wr_en & bus.UPK_TX_EOP;
   assign wr_word   = {bus.UPK_TX_SOP, bus.UPK_TX_EOP, bus.UPK_TX_MASK, bus.UPK_TX_DATA};

   // A one-beat packet written in the same cycle the previous EOP leaves can
   // be the next head while the FIFO is still empty: forward it directly.
   assign head_word = (occ == '0) ? wr_word : mem[rptr[AW-1:0]];

   assign pop       = (state == O_SEND) & bus.TX_ST_READY;
   assign pop_eop   = pop & out_word[66];
   assign pkt_cnt_nxt = pkt_cnt + PW'(wr_eop) - PW'(pop_eop);

   always_ff @(posedge PCIE_CLK) begin
      if (wr_en) mem[wptr[AW-1:0]] <= wr_word;
   end

   always_ff @(posedge PCIE_CLK or negedge PCIE_RST_N) begin
      if (!PCIE_RST_N) begin
         state    <= O_IDLE;
         wptr     <= '0;
         rptr     <= '0;
         pkt_cnt  <= '0;
         out_word <= '0;
         ack_q    <= 1'b0;
         err_ovf  <= 1'b0;
      end else begin
         state   <= state_nxt;
         wptr    <= wptr + PW'(wr_en);
         rptr    <= rptr + PW'(load);
         pkt_cnt <= pkt_cnt_nxt;
         ack_q   <= bus.UPK_TX_REQ & (free_cnt >= PW'(P_MAX_BEATS + P_SKID));
         if (load) out_word <= head_word;
         if (bus.UPK_TX_DVLD & full) err_ovf <= 1'b1;
      end
   end

   // The output register is the show-ahead head: it is refilled on entry to
   // O_SEND and after every accepted beat unless the last stored packet ended.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         O_IDLE: begin
            if (pkt_cnt != '0) begin
               state_nxt = O_SEND;
               load      = 1'b1;
            end
         end
         O_SEND: begin
            if (pop) begin
               if (pop_eop && (pkt_cnt_nxt == '0)) state_nxt = O_IDLE;
               else                                load      = 1'b1;
            end
         end
         default: state_nxt = O_IDLE;
      endcase
   end

   assign bus.UPK_TX_ACK  = ack_q;
   assign bus.TX_ST_VALID = (state == O_SEND);
   assign bus.TX_ST_DATA  = out_word[63:0];
   assign bus.TX_ST_SOP   = out_word[67];
   assign bus.TX_ST_EOP   = out_word[66];
   assign bus.TX_ST_EMPTY = out_word[66] & (out_word[65:64] == 2'b01);

`ifdef PCIE_UP_TXBUF_ERRCHK_EN
   logic          pkt_open, err_frm, err_big, frm_hit, big_hit;
   logic [PW-1:0] beat_cnt;

   // Checks the raw arbiter stream, independent of whether a beat was dropped.
   // END on the EOP beat itself closes the packet and is not a framing error.
   always_comb begin
      frm_hit = (bus.UPK_TX_DVLD &  bus.UPK_TX_SOP &  pkt_open) |
                (bus.UPK_TX_DVLD & ~bus.UPK_TX_SOP & ~pkt_open) |
                (bus.UPK_TX_END  &  pkt_open & ~(bus.UPK_TX_DVLD & bus.UPK_TX_EOP));
      big_hit = bus.UPK_TX_DVLD & ~bus.UPK_TX_SOP & pkt_open &
                (beat_cnt >= PW'(P_MAX_BEATS));
   end

   always_ff @(posedge PCIE_CLK or negedge PCIE_RST_N) begin
      if (!PCIE_RST_N) begin
         pkt_open <= 1'b0;
         beat_cnt <= '0;
         err_frm  <= 1'b0;
         err_big  <= 1'b0;
      end else begin
         if (bus.UPK_TX_DVLD) begin
            if (bus.UPK_TX_SOP) begin
               pkt_open <= ~bus.UPK_TX_EOP;
               beat_cnt <= PW'(1);
            end else if (pkt_open) begin
               pkt_open <= ~bus.UPK_TX_EOP;
               if (beat_cnt != '1) beat_cnt <= beat_cnt + PW'(1);
            end
         end
         if (frm_hit) err_frm <= 1'b1;
         if (big_hit) err_big <= 1'b1;
      end
   end

   assign ERR_FLAG = {err_big, err_frm, err_ovf};
`else
   logic unused_end;
   assign unused_end = bus.UPK_TX_END;
   assign ERR_FLAG   = {2'b00, err_ovf};
`endif

endmodule

// File: doc/pcie_up_txbuf.md
# pcie_up_txbuf

Upload transmit buffer between the upload arbiter and the PCIe hard IP TX streaming port. It accepts the arbitrated UPK_TX_* beat stream into a store-and-forward packet FIFO and grants UPK_TX_ACK only while a worst-case packet plus in-flight beats still fits. It forwards complete packets only, with no gaps, as Avalon-ST TX beats (readyLatency 0).

## Interface
- P_DEPTH, 256: FIFO depth in 64-bit beats; power of two, ≥ 2×P_MAX_BEATS+8.
- P_MAX_BEATS, 34: largest packet in beats (header + 256 B payload).
- P_SKID, 4: beats that may arrive after ACK deasserts (arbiter register stage + channel reaction).
- PCIE_CLK  in  1  sole clock.
- PCIE_RST_N  in  1  asynchronous, active-low reset.
- UPK_TX_REQ  in  1  arbiter has a granted channel.
- UPK_TX_ACK  out  1  space-available level to the arbiter.
- UPK_TX_DVLD  in  1  beat valid.
- UPK_TX_DATA  in  64  beat data.
- UPK_TX_MASK  in  2  bit0 = lower dword valid, bit1 = upper dword valid.
- UPK_TX_SOP / UPK_TX_EOP  in  1  packet start / end beat.
- UPK_TX_END  in  1  channel transfer finished; used only by the checker.
- TX_ST_VALID  out  1  output beat valid.
- TX_ST_READY  in  1  hard IP accepts the beat when VALID&READY.
- TX_ST_DATA  out  64;  TX_ST_SOP, TX_ST_EOP  out  1;  TX_ST_EMPTY  out  1  (1 = upper dword empty).
- ERR_FLAG  out  3  sticky errors: [0] overflow, [1] framing, [2] oversize.

## Operation
- FIFO word: {SOP, EOP, MASK, DATA}, 68 bits. Write every cycle DVLD=1. Binary write/read pointers with one extra wrap bit. Occupancy = wptr − rptr.
- ACK register: next = UPK_TX_REQ & (P_DEPTH − occupancy ≥ P_MAX_BEATS + P_SKID). Sources must begin a new SOP only while ACK=1. A packet already started always completes.
- Write when full: the beat is dropped, the pointers hold, and ERR_FLAG[0] sets.
- pkt_cnt counts complete packets stored: +1 on a written EOP beat, −1 on an accepted EOP beat. Both in one cycle leave it unchanged. Its width is log2(P_DEPTH)+1.
- Output FSM:
  - O_IDLE → O_SEND when pkt_cnt ≠ 0.
  - O_SEND: VALID=1 and the head word is presented from a show-ahead register. Each VALID&READY pops one word.
  - On an accepted EOP beat: stay in O_SEND if pkt_cnt after decrement ≠ 0, else go to O_IDLE.
- Output mapping: TX_ST_EMPTY = EOP & (MASK == 2'b01). A MASK of 2'b00 or 2'b10 on a beat is passed through with EMPTY=0.
- Outputs stay stable while VALID=1 and READY=0.
- UPK_TX_END has no datapath effect.

## Timing
- Reset values: UPK_TX_ACK=0, TX_ST_VALID=0, TX_ST_DATA=0, TX_ST_SOP=0, TX_ST_EOP=0, TX_ST_EMPTY=0, ERR_FLAG=0. The FIFO pointers, pkt_cnt and the FSM (O_IDLE) are cleared too.
- Reset asserted mid-packet: all in-flight and buffered data is discarded. After release, the first accepted beat must be an SOP.
- ACK latency: 1 cycle from REQ or an occupancy change.
- Cut-through latency: EOP written at cycle N; TX_ST_VALID with that packet's SOP at N+2 at the earliest, when the FIFO was otherwise empty.
- Throughput: 1 beat/cycle in both directions simultaneously. Back-to-back packets leave no idle cycle between an accepted EOP and the next SOP.
- Pointer wrap at P_DEPTH: seamless, no bubble.

## Configuration
- PCIE_UP_TXBUF_ERRCHK_EN defined: ERR_FLAG[1] and ERR_FLAG[2] are implemented.
  - [1] sets on any of: SOP while a packet is open; DVLD with no open packet and SOP=0; END while a packet is open.
  - [2] sets when a packet's beat count exceeds P_MAX_BEATS.
  - Beats are still written when these errors set; only ERR_FLAG[0] causes a drop.
- Macro undefined: ERR_FLAG[2:1] are tied to 0 and the checker logic is absent. ERR_FLAG[0] is always present.

## Test plan
- Reset, then a 3-beat packet (SOP on beat 0, EOP on beat 2 with MASK=2'b01) with READY=1. Required: 3 output beats starting 2 cycles after EOP, EMPTY=1 on the last beat only, data identical.
- Two 34-beat packets back-to-back, READY=1. Required: 68 consecutive VALID cycles with no gap at the packet boundary.
- READY held 0 and REQ held 1 while feeding packets. Required: ACK falls when free < 38 (P_MAX_BEATS + P_SKID); no ERR_FLAG[0]; releasing READY drains every packet.
- Force 257 beats with READY=0 while ignoring ACK. Required: ERR_FLAG[0]=1; the first 256 beats are delivered intact once READY=1.
- Toggle READY 1/0 every cycle over 300 packets so the pointers wrap. Required: output beat order and content match the input; pkt_cnt returns to 0.
- With PCIE_UP_TXBUF_ERRCHK_EN defined: an SOP during an open packet sets ERR_FLAG=3'b010; a 35-beat packet sets ERR_FLAG[2]. Reset clears ERR_FLAG to 0.
